// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory-operand issue queue.
//   - size encodings (in_size) and the byte count each one stands for
//   - {write, read} access-type encodings (in_rw / out_rw)
//   - issue FSM state constants
package mem_issue_queue_pkg;

  // Operand size encodings: bytes = 1 << size
  localparam logic [1:0] SZ_1B = 2'b00;
  localparam logic [1:0] SZ_2B = 2'b01;
  localparam logic [1:0] SZ_4B = 2'b10;
  localparam logic [1:0] SZ_8B = 2'b11;

  // Access type encodings, bit 1 = write, bit 0 = read
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RD   = 2'b01;
  localparam logic [1:0] RW_WR   = 2'b10;
  localparam logic [1:0] RW_RDWR = 2'b11;

  // Issue FSM: IDLE (no beat), FIRST (head entry, first/only beat),
  // SECOND (upper half of a line-crossing head entry)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } issue_state_e;

  // Byte count (1..8) for a size encoding
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_issue_split.sv
// Line-crossing split helper (purely combinational).
// Given an effective address and access byte count, reports whether the access
// straddles a cache-line boundary and produces the byte count of the first beat
// plus the address/byte count of the second beat.
// Ports:
//   addr_i         access start address
//   bytes_i        access length in bytes (1..8)
//   cross_o        access crosses into the next line
//   first_bytes_o  bytes carried by the first beat
//   sec_addr_o     base address of the next line
//   sec_bytes_o    bytes carried by the second beat (only meaningful if cross_o)
module mem_issue_split #(
  parameter int AW         = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    bytes_i,
  output logic          cross_o,
  output logic [3:0]    first_bytes_o,
  output logic [AW-1:0] sec_addr_o,
  output logic [3:0]    sec_bytes_o
);

  // Offset width; lines are assumed to hold at least one 8-byte access.
  localparam int OW = $clog2(LINE_BYTES);

  logic [OW:0] off_ext;
  logic [OW:0] off_end;

  assign off_ext = {1'b0, addr_i[OW-1:0]};
  assign off_end = off_ext + (OW+1)'(bytes_i);
  assign cross_o = off_end > (OW+1)'(LINE_BYTES);

  // When crossing, LINE_BYTES - offset is at most 7, so 4-bit modular
  // arithmetic gives the exact first-beat length.
  assign first_bytes_o = cross_o ? (4'(LINE_BYTES) - 4'(off_ext)) : bytes_i;
  assign sec_bytes_o   = bytes_i - first_bytes_o;
  assign sec_addr_o    = {addr_i[AW-1:OW] + (AW-OW)'(1), {OW{1'b0}}};

endmodule

// File: rtl/mem_issue_queue.sv
// Memory-operand issue queue.
// Accepts a group of up to NUM_PORTS memory requests per cycle, computes the
// effective address (stack pushes pre-decrement) and segment-limit exception at
// enqueue time, stores entries in an inline FIFO, and issues them to the cache
// one beat at a time, splitting line-crossing accesses into two beats.
// Ports:
//   clk, clr                  clock, synchronous active-low reset
//   in_valid/in_addr/in_size  per-port request valid, address, size
//   in_rw/in_ispush           per-port {write,read}, stack-push flag
//   in_seg_max                per-port last legal segment address
//   in_ptcid                  ptc id shared by the group
//   in_ready                  group accepted this cycle (= ~full)
//   out_*                     beat to the cache, valid/ready handshake
//   full, empty               queue status
// Handshake: a beat transfers on a rising edge where out_valid and out_ready are
// both 1; while out_valid=1 and out_ready=0 every out_* field holds stable.
// A group transfers on a rising edge where in_ready=1 and any in_valid is set.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DEPTH      = 4,
  parameter int AW         = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NUM_PORTS-1:0]    in_valid,
  input  logic [NUM_PORTS*AW-1:0] in_addr,
  input  logic [2*NUM_PORTS-1:0]  in_size,
  input  logic [2*NUM_PORTS-1:0]  in_rw,
  input  logic [NUM_PORTS-1:0]    in_ispush,
  input  logic [NUM_PORTS*AW-1:0] in_seg_max,
  input  logic [6:0]              in_ptcid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW-1:0]           out_addr,
  output logic [3:0]              out_bytes,
  output logic [1:0]              out_rw,
  output logic [1:0]              out_port,
  output logic [6:0]              out_ptcid,
  output logic                    out_second,
  output logic                    out_exc,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage (data fields are not reset)
  logic [AW-1:0] ent_addr_q  [DEPTH];
  logic [1:0]    ent_size_q  [DEPTH];
  logic [1:0]    ent_rw_q    [DEPTH];
  logic [1:0]    ent_port_q  [DEPTH];
  logic [6:0]    ent_ptcid_q [DEPTH];
  logic          ent_exc_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  // Issue FSM and registered beat outputs
  issue_state_e  state_q;
  logic          out_valid_q, out_exc_q, out_second_q;
  logic          pend_q;      // current FIRST beat has a second beat to follow
  logic [AW-1:0] out_addr_q;
  logic [3:0]    out_bytes_q;
  logic [1:0]    out_rw_q, out_port_q;
  logic [6:0]    out_ptcid_q;

  // ---------------------------------------------------------------------------
  // Enqueue: per-port effective address, exception and FIFO slot offset
  // ---------------------------------------------------------------------------
  logic [AW-1:0] p_eff   [NUM_PORTS];
  logic          p_exc   [NUM_PORTS];
  logic          enq_en  [NUM_PORTS];
  logic [PW-1:0] enq_off [NUM_PORTS];
  logic [CW-1:0] n_enq;

  always_comb begin : enq_calc
    logic [3:0]  b;
    logic [AW:0] last;
    n_enq = '0;
    b     = '0;
    last  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      b        = size_bytes(in_size[2*p +: 2]);
      p_eff[p] = in_ispush[p] ? (in_addr[p*AW +: AW] - AW'(b)) : in_addr[p*AW +: AW];
      // AW+1-bit sum so a carry out of the address space also flags exc
      last     = {1'b0, p_eff[p]} + (AW+1)'(b) - (AW+1)'(1);
      p_exc[p] = last > {1'b0, in_seg_max[p*AW +: AW]};
      // Valid ports pack densely into consecutive slots, port 0 first
      enq_off[p] = PW'(n_enq);
      enq_en[p]  = in_ready && in_valid[p] && (in_rw[2*p +: 2] != RW_NONE);
      if (enq_en[p]) n_enq = n_enq + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (enq_en[p]) begin
        ent_addr_q [wr_ptr_q + enq_off[p]] <= p_eff[p];
        ent_size_q [wr_ptr_q + enq_off[p]] <= in_size[2*p +: 2];
        ent_rw_q   [wr_ptr_q + enq_off[p]] <= in_rw[2*p +: 2];
        ent_port_q [wr_ptr_q + enq_off[p]] <= 2'(p);
        ent_ptcid_q[wr_ptr_q + enq_off[p]] <= in_ptcid;
        ent_exc_q  [wr_ptr_q + enq_off[p]] <= p_exc[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  logic hs, pop, more;

  assign hs   = out_valid_q && out_ready;
  // The head entry leaves on its last beat
  assign pop  = hs && ((state_q == ST_SECOND) || ((state_q == ST_FIRST) && !pend_q));
  // Another stored entry exists behind the head
  assign more = count_q > CW'(1);

  // When popping, the next beat comes from the entry behind the head; the split
  // unit looks at that entry so back-to-back issue needs no bubble.
  logic [PW-1:0] sel_ptr;
  logic [AW-1:0] sel_addr;
  logic [3:0]    sel_bytes;
  logic          sel_exc;

  assign sel_ptr   = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
  assign sel_addr  = ent_addr_q[sel_ptr];
  assign sel_bytes = size_bytes(ent_size_q[sel_ptr]);
  assign sel_exc   = ent_exc_q[sel_ptr];

  logic          sp_cross;
  logic [3:0]    sp_first_bytes, sp_sec_bytes;
  logic [AW-1:0] sp_sec_addr;

  mem_issue_split #(
    .AW         (AW),
    .LINE_BYTES (LINE_BYTES)
  ) u_split (
    .addr_i        (sel_addr),
    .bytes_i       (sel_bytes),
    .cross_o       (sp_cross),
    .first_bytes_o (sp_first_bytes),
    .sec_addr_o    (sp_sec_addr),
    .sec_bytes_o   (sp_sec_bytes)
  );

  // FSM transition decode
  logic load_first, go_second, go_idle;

  always_comb begin
    load_first = 1'b0;
    go_second  = 1'b0;
    go_idle    = 1'b0;
    unique case (state_q)
      ST_IDLE:   load_first = (count_q != '0);
      ST_FIRST: begin
        if (hs) begin
          if (pend_q)    go_second  = 1'b1;
          else if (more) load_first = 1'b1;
          else           go_idle    = 1'b1;
        end
      end
      ST_SECOND: begin
        if (hs) begin
          if (more) load_first = 1'b1;
          else      go_idle    = 1'b1;
        end
      end
      default:   go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_exc_q    <= 1'b0;
      out_second_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      count_q  <= count_q + n_enq - CW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(n_enq);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      if (load_first) begin
        state_q      <= ST_FIRST;
        out_valid_q  <= 1'b1;
        out_addr_q   <= sel_addr;
        // An exception beat reports the full size and performs no access
        out_bytes_q  <= sel_exc ? sel_bytes : sp_first_bytes;
        out_rw_q     <= sel_exc ? RW_NONE : ent_rw_q[sel_ptr];
        out_port_q   <= ent_port_q[sel_ptr];
        out_ptcid_q  <= ent_ptcid_q[sel_ptr];
        out_exc_q    <= sel_exc;
        out_second_q <= 1'b0;
        pend_q       <= sp_cross && !sel_exc;
      end else if (go_second) begin
        state_q      <= ST_SECOND;
        out_addr_q   <= sp_sec_addr;
        out_bytes_q  <= sp_sec_bytes;
        out_second_q <= 1'b1;
        pend_q       <= 1'b0;
      end else if (go_idle) begin
        state_q      <= ST_IDLE;
        out_valid_q  <= 1'b0;
        out_exc_q    <= 1'b0;
        out_second_q <= 1'b0;
        pend_q       <= 1'b0;
      end
    end
  end

  assign full       = (CW'(DEPTH) - count_q) < CW'(NUM_PORTS);
  assign in_ready   = ~full;
  assign empty      = (count_q == '0) && (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_bytes  = out_bytes_q;
  assign out_rw     = out_rw_q;
  assign out_port   = out_port_q;
  assign out_ptcid  = out_ptcid_q;
  assign out_second = out_second_q;
  assign out_exc    = out_exc_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed testbench for mem_issue_queue (NUM_PORTS=2, DEPTH=4, AW=32, LINE=16).
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam logic [31:0] SEG_ALL = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             clr;
  logic [NP-1:0]    in_valid;
  logic [NP*AW-1:0] in_addr;
  logic [2*NP-1:0]  in_size;
  logic [2*NP-1:0]  in_rw;
  logic [NP-1:0]    in_ispush;
  logic [NP*AW-1:0] in_seg_max;
  logic [6:0]       in_ptcid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_addr;
  logic [3:0]       out_bytes;
  logic [1:0]       out_rw;
  logic [1:0]       out_port;
  logic [6:0]       out_ptcid;
  logic             out_second;
  logic             out_exc;
  logic             full;
  logic             empty;

  mem_issue_queue #(
    .NUM_PORTS  (NP),
    .DEPTH      (4),
    .AW         (AW),
    .LINE_BYTES (16)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_size    (in_size),
    .in_rw      (in_rw),
    .in_ispush  (in_ispush),
    .in_seg_max (in_seg_max),
    .in_ptcid   (in_ptcid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_bytes  (out_bytes),
    .out_rw     (out_rw),
    .out_port   (out_port),
    .out_ptcid  (out_ptcid),
    .out_second (out_second),
    .out_exc    (out_exc),
    .full       (full),
    .empty      (empty)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [48:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat layout: {addr, bytes, rw, port, ptcid, second, exc}
  function automatic logic [48:0] mk_beat(input logic [31:0] a, input logic [3:0] b,
                                          input logic [1:0] rw, input logic [1:0] port,
                                          input logic [6:0] ptc, input logic sec,
                                          input logic exc);
    return {a, b, rw, port, ptc, sec, exc};
  endfunction

  function automatic logic [48:0] obs_beat();
    return {out_addr, out_bytes, out_rw, out_port, out_ptcid, out_second, out_exc};
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    in_valid   = '0;
    in_addr    = '0;
    in_size    = '0;
    in_rw      = '0;
    in_ispush  = '0;
    in_seg_max = '1;
    in_ptcid   = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [1:0] sz,
                          input logic [1:0] rw, input logic push, input logic [31:0] sm);
    in_valid[p]          = 1'b1;
    in_addr[p*AW +: AW]  = a;
    in_size[2*p +: 2]    = sz;
    in_rw[2*p +: 2]      = rw;
    in_ispush[p]         = push;
    in_seg_max[p*AW +: AW] = sm;
  endtask

  // Called at a falling edge with ports set up; holds the group until accepted.
  task automatic send_group(input logic [6:0] ptc);
    int w = 0;
    in_ptcid = ptc;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    clear_inputs();
  endtask

  // Takes beats with out_ready=1 and compares them against exp_q in order.
  task automatic drain(input string tag, input int budget);
    logic [48:0] e;
    int c = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && c < budget) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check_eq(tag, 64'(obs_beat()), 64'(e));
      end
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      check_eq({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int seen;
    clr = 1'b0;
    out_ready = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_out_valid",  64'(out_valid),  64'd0);
    check_eq("rst_empty",      64'(empty),      64'd1);
    check_eq("rst_full",       64'(full),       64'd0);
    check_eq("rst_in_ready",   64'(in_ready),   64'd1);
    check_eq("rst_out_exc",    64'(out_exc),    64'd0);
    check_eq("rst_out_second", 64'(out_second), 64'd0);
    clr = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", 64'(out_valid), 64'd0);

    // Two-port group: read and write, no crossing
    out_ready = 1'b1;
    exp_q.push_back(mk_beat(32'h1000, 4'd4, RW_RD, 2'd0, 7'h15, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h2004, 4'd2, RW_WR, 2'd1, 7'h15, 1'b0, 1'b0));
    set_port(0, 32'h1000, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    set_port(1, 32'h2004, SZ_2B, RW_WR, 1'b0, SEG_ALL);
    send_group(7'h15);
    drain("grp_rd_wr", 40);
    check_eq("empty_after_grp", 64'(empty), 64'd1);

    // Line-crossing read splits into 2+2
    exp_q.push_back(mk_beat(32'h100E, 4'd2, RW_RD, 2'd0, 7'h21, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h1010, 4'd2, RW_RD, 2'd0, 7'h21, 1'b1, 1'b0));
    set_port(0, 32'h100E, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    send_group(7'h21);
    drain("split", 40);

    // Stack push pre-decrements
    exp_q.push_back(mk_beat(32'h7FFC, 4'd4, RW_WR, 2'd0, 7'h22, 1'b0, 1'b0));
    set_port(0, 32'h8000, SZ_4B, RW_WR, 1'b1, SEG_ALL);
    send_group(7'h22);
    drain("push", 40);

    // Segment limit exceeded: single exception beat even though it would cross
    exp_q.push_back(mk_beat(32'h0FFE, 4'd4, RW_NONE, 2'd0, 7'h23, 1'b0, 1'b1));
    set_port(0, 32'h0FFE, SZ_4B, RW_RD, 1'b0, 32'h0000_0FFF);
    send_group(7'h23);
    drain("seg_exc", 40);

    // Last byte exactly at seg_max is legal, and the access splits
    exp_q.push_back(mk_beat(32'h0FFE, 4'd2, RW_RD, 2'd1, 7'h24, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h1000, 4'd2, RW_RD, 2'd1, 7'h24, 1'b1, 1'b0));
    set_port(1, 32'h0FFE, SZ_4B, RW_RD, 1'b0, 32'h0000_1001);
    send_group(7'h24);
    drain("seg_edge", 40);

    // Address wrap past 2^AW raises exception
    exp_q.push_back(mk_beat(32'hFFFF_FFFE, 4'd4, RW_NONE, 2'd0, 7'h25, 1'b0, 1'b1));
    set_port(0, 32'hFFFF_FFFE, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    send_group(7'h25);
    drain("carry_exc", 40);

    // rw=00 port is not enqueued; port 1 still goes
    exp_q.push_back(mk_beat(32'h3000, 4'd1, RW_RD, 2'd1, 7'h26, 1'b0, 1'b0));
    set_port(0, 32'h3100, SZ_4B, RW_NONE, 1'b0, SEG_ALL);
    set_port(1, 32'h3000, SZ_1B, RW_RD, 1'b0, SEG_ALL);
    send_group(7'h26);
    drain("rw_none_skip", 40);
    repeat (3) @(negedge clk);
    check_eq("rw_none_no_extra", 64'(out_valid), 64'd0);
    check_eq("rw_none_empty",    64'(empty),     64'd1);

    // Fill to full with out_ready low, third group refused, then drain in order
    out_ready = 1'b0;
    set_port(0, 32'h4000, SZ_8B, RW_RD, 1'b0, SEG_ALL);
    set_port(1, 32'h4008, SZ_1B, RW_WR, 1'b0, SEG_ALL);
    send_group(7'h41);
    check_eq("full_at_2", 64'(full), 64'd0);
    set_port(0, 32'h4010, SZ_2B, RW_RD, 1'b0, SEG_ALL);
    set_port(1, 32'h4020, SZ_4B, RW_WR, 1'b0, SEG_ALL);
    send_group(7'h42);
    check_eq("full_at_4",      64'(full),      64'd1);
    check_eq("in_ready_at_4",  64'(in_ready),  64'd0);
    check_eq("stall_valid",    64'(out_valid), 64'd1);
    check_eq("stall_addr0",    64'(out_addr),  64'h4000);
    set_port(0, 32'h5000, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    set_port(1, 32'h5004, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    in_ptcid = 7'h43;
    @(negedge clk);
    check_eq("stall_addr1", 64'(out_addr), 64'h4000);
    check_eq("still_full",  64'(full),     64'd1);
    clear_inputs();
    exp_q.push_back(mk_beat(32'h4000, 4'd8, RW_RD, 2'd0, 7'h41, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h4008, 4'd1, RW_WR, 2'd1, 7'h41, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h4010, 4'd2, RW_RD, 2'd0, 7'h42, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h4020, 4'd4, RW_WR, 2'd1, 7'h42, 1'b0, 1'b0));
    drain("full_drain", 60);
    repeat (3) @(negedge clk);
    check_eq("third_group_dropped", 64'(out_valid), 64'd0);
    check_eq("full_empty_after",    64'(empty),     64'd1);

    // Enqueue while issuing: three back-to-back groups overlapping the drain
    exp_q.push_back(mk_beat(32'h6000, 4'd4, RW_RD, 2'd0, 7'h11, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h6104, 4'd4, RW_WR, 2'd1, 7'h11, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h600C, 4'd4, RW_RD, 2'd0, 7'h22, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h6010, 4'd4, RW_RD, 2'd0, 7'h22, 1'b1, 1'b0));
    exp_q.push_back(mk_beat(32'h6200, 4'd1, RW_RD, 2'd1, 7'h22, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h62FE, 4'd2, RW_WR, 2'd0, 7'h33, 1'b0, 1'b0));
    exp_q.push_back(mk_beat(32'h6020, 4'd4, RW_RD, 2'd1, 7'h33, 1'b0, 1'b0));
    fork
      begin
        set_port(0, 32'h6000, SZ_4B, RW_RD, 1'b0, SEG_ALL);
        set_port(1, 32'h6104, SZ_4B, RW_WR, 1'b0, SEG_ALL);
        send_group(7'h11);
        set_port(0, 32'h600C, SZ_8B, RW_RD, 1'b0, SEG_ALL);
        set_port(1, 32'h6200, SZ_1B, RW_RD, 1'b0, SEG_ALL);
        send_group(7'h22);
        // Ends exactly on the line boundary: no split
        set_port(0, 32'h6300, SZ_2B, RW_WR, 1'b1, SEG_ALL);
        set_port(1, 32'h6020, SZ_4B, RW_RD, 1'b0, SEG_ALL);
        send_group(7'h33);
      end
      begin
        drain("overlap", 200);
      end
    join
    repeat (3) @(negedge clk);
    check_eq("overlap_empty", 64'(empty), 64'd1);

    // Reset while the second half of a split is pending
    out_ready = 1'b0;
    set_port(0, 32'h100E, SZ_4B, RW_RD, 1'b0, SEG_ALL);
    send_group(7'h55);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("rs_first", 64'({out_valid, out_second, out_addr}), 64'({1'b1, 1'b0, 32'h100E}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("rs_second", 64'({out_valid, out_second, out_addr}), 64'({1'b1, 1'b1, 32'h1010}));
    clr = 1'b0;
    @(negedge clk);
    check_eq("rs_valid",  64'(out_valid),  64'd0);
    check_eq("rs_empty",  64'(empty),      64'd1);
    check_eq("rs_second_clr", 64'(out_second), 64'd0);
    clr = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("rs_no_beat", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
